max_min_tree_n: RTL and testbench

- Parametrised successor to the fixed 5-input max block.
- Finds the max or min of N streamed BW-bit elements using a pipelined pairwise comparison tree. Also reports the winning element's index.
- Mode is selectable per sample, with optional signed compare. A valid strobe travels alongside the data.
- Sits in the feature-extraction path, after window/line-buffer stages, feeding pooling and peak-detect logic.

---
 rtl/max_min_tree_n.sv | 103 ++++++++++
 tb/tb_max_min_tree_n.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/max_min_tree_n.sv
// max_min_tree_n: pipelined max/min tree with winner index; optional peak hold via MAX_MIN_TREE_PEAK_HOLD_EN
module max_min_tree_n #(
  parameter int BW = 8,
  parameter int N = 5,
  parameter int SIGNED = 0,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1,
  localparam int LAT = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            den_in,
  input  logic            mode_min,
  input  logic [N*BW-1:0] data_in,
  output logic [BW-1:0]   data_out,
  output logic [IDXW-1:0] idx_out,
  output logic            den_out
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
  ,
  input  logic            peak_clr,
  output logic [BW-1:0]   peak_val,
  output logic [IDXW-1:0] peak_idx,
  output logic            peak_vld
`endif
);
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
  localparam int MLAST = LAT;
`else
  localparam int MLAST = LAT - 1;
`endif
  function automatic logic beats(input logic mn, input logic [BW-1:0] a, input logic [BW-1:0] b);
    if (SIGNED != 0) return mn ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    return mn ? (a < b) : (a > b);
  endfunction
  genvar k, j;
  for (k = 0; k <= LAT; k++) begin : lvl
    localparam int C = (N + (1 << k) - 1) >> k;
    logic [C-1:0][BW-1:0]   v;
    logic [C-1:0][IDXW-1:0] ix;
    logic                   d;
    if (k == 0) begin : in
      assign v = data_in;
      assign d = den_in;
      for (j = 0; j < C; j++) begin : e
        assign ix[j] = IDXW'(j);
      end
    end else begin : st
      localparam int P = (N + (1 << (k - 1)) - 1) >> (k - 1);
      logic [C-1:0][BW-1:0]   nv;
      logic [C-1:0][IDXW-1:0] ni;
      for (j = 0; j < C; j++) begin : e
        if (2 * j + 1 < P) begin : c
          logic w;
          assign w = beats(lvl[k-1].mb.m, lvl[k-1].v[2*j+1], lvl[k-1].v[2*j]);
          assign nv[j] = w ? lvl[k-1].v[2*j+1] : lvl[k-1].v[2*j];
          assign ni[j] = w ? lvl[k-1].ix[2*j+1] : lvl[k-1].ix[2*j];
        end else begin : p
          assign nv[j] = lvl[k-1].v[2*j];
          assign ni[j] = lvl[k-1].ix[2*j];
        end
      end
      // stage register: winners, unpaired pass-through and valid strobe
      always_ff @(posedge clk) begin
        if (rst) begin
          v <= '0;
          ix <= '0;
          d <= 1'b0;
        end else begin
          v <= nv;
          ix <= ni;
          d <= lvl[k-1].d;
        end
      end
    end
    if (k <= MLAST) begin : mb
      logic m;
      if (k == 0) begin : m0
        assign m = mode_min;
      end else begin : mk
        // per-sample mode bit travels with its data
        always_ff @(posedge clk) m <= rst ? 1'b0 : lvl[k-1].mb.m;
      end
    end
  end
  assign data_out = lvl[LAT].v[0];
  assign idx_out = lvl[LAT].ix[0];
  assign den_out = lvl[LAT].d;
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
  logic take;
  assign take = den_out & (~peak_vld | peak_clr | beats(lvl[LAT].mb.m, data_out, peak_val));
  // held peak: load on a strictly better result, first sample or clear-and-load
  always_ff @(posedge clk) begin
    if (rst || (peak_clr && !take)) begin
      peak_val <= '0;
      peak_idx <= '0;
      peak_vld <= 1'b0;
    end else if (take) begin
      peak_val <= data_out;
      peak_idx <= idx_out;
      peak_vld <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_max_min_tree_n.sv
// tb_max_min_tree_n: random and directed checks of max_min_tree_n against a linear-scan model
module tb_max_min_tree_n;
  typedef struct packed {logic v; logic m; logic [7:0] d; logic [2:0] i;} ent_t;
  logic clk = 0, rst, den_in, mode_min, pc;
  logic [39:0] d5;
  logic [63:0] d8;
  logic [7:0] val5, vals, val8, val1;
  logic [2:0] idx5, idxs, idx8;
  logic [0:0] idx1;
  logic den5, dens, den8, den1;
  logic [7:0] pk_val;
  logic [2:0] pk_idx;
  logic pk_vld;
  ent_t p5[3], ps[3], p8[3], p1;
  logic [7:0] mpd;
  logic [2:0] mpi;
  logic mpv;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  max_min_tree_n #(.BW(8), .N(5), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .den_in(den_in), .mode_min(mode_min), .data_in(d5),
    .data_out(val5), .idx_out(idx5), .den_out(den5)
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
    , .peak_clr(pc), .peak_val(pk_val), .peak_idx(pk_idx), .peak_vld(pk_vld)
`endif
  );
  max_min_tree_n #(.BW(8), .N(5), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .den_in(den_in), .mode_min(mode_min), .data_in(d5),
    .data_out(vals), .idx_out(idxs), .den_out(dens)
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
    , .peak_clr(pc), .peak_val(), .peak_idx(), .peak_vld()
`endif
  );
  max_min_tree_n #(.BW(8), .N(8), .SIGNED(0)) dut8 (
    .clk(clk), .rst(rst), .den_in(den_in), .mode_min(mode_min), .data_in(d8),
    .data_out(val8), .idx_out(idx8), .den_out(den8)
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
    , .peak_clr(pc), .peak_val(), .peak_idx(), .peak_vld()
`endif
  );
  max_min_tree_n #(.BW(8), .N(1), .SIGNED(0)) dut1 (
    .clk(clk), .rst(rst), .den_in(den_in), .mode_min(mode_min), .data_in(d8[7:0]),
    .data_out(val1), .idx_out(idx1), .den_out(den1)
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
    , .peak_clr(pc), .peak_val(), .peak_idx(), .peak_vld()
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int sx(input logic [7:0] y, input bit sg);
    return sg ? int'($signed(y)) : int'(y);
  endfunction
  function automatic ent_t model_e(input logic [63:0] x, input int n, input logic mn, input bit sg, input logic dn);
    ent_t e;
    int b, c;
    e.v = dn; e.m = mn; e.i = 0; e.d = x[7:0]; b = sx(x[7:0], sg);
    for (int i = 1; i < n; i++) begin
      c = sx(x[i*8+:8], sg);
      if (mn ? c < b : c > b) begin b = c; e.d = x[i*8+:8]; e.i = 3'(i); end
    end
    return e;
  endfunction
  function automatic logic [39:0] pk5(input logic [7:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction
  task automatic cyc(input logic r, input logic dn, input logic mn, input logic [39:0] a);
    logic [63:0] b;
    ent_t o;
    b = {$urandom, $urandom};
    rst = r; den_in = dn; mode_min = mn; d5 = a; d8 = b;
    @(posedge clk);
    o = p5[2];
    if (r || (pc && !(o.v && (!mpv || pc || (o.m ? o.d < mpd : o.d > mpd))))) begin
      mpd = 0; mpi = 0; mpv = 0;
    end else if (o.v && (!mpv || pc || (o.m ? o.d < mpd : o.d > mpd))) begin
      mpd = o.d; mpi = o.i; mpv = 1;
    end
    for (int i = 2; i > 0; i--) begin p5[i] = p5[i-1]; ps[i] = ps[i-1]; p8[i] = p8[i-1]; end
    if (r) begin
      for (int i = 0; i < 3; i++) begin p5[i] = '0; ps[i] = '0; p8[i] = '0; end
      p1 = '0;
    end else begin
      p5[0] = model_e({24'b0, a}, 5, mn, 0, dn);
      ps[0] = model_e({24'b0, a}, 5, mn, 1, dn);
      p8[0] = model_e(b, 8, mn, 0, dn);
      p1 = model_e(b, 1, mn, 0, dn);
    end
    #1;
    chk("den5", den5, p5[2].v); chk("val5", val5, p5[2].d); chk("idx5", idx5, p5[2].i);
    chk("dens", dens, ps[2].v); chk("vals", vals, ps[2].d); chk("idxs", idxs, ps[2].i);
    chk("den8", den8, p8[2].v); chk("val8", val8, p8[2].d); chk("idx8", idx8, p8[2].i);
    chk("den1", den1, p1.v); chk("val1", val1, p1.d); chk("idx1", idx1, p1.i);
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
    chk("pkv", pk_vld, mpv); chk("pkd", pk_val, mpd); chk("pki", pk_idx, mpi);
`endif
  endtask
  initial begin
    logic [39:0] t;
    pc = 0; mpd = 0; mpi = 0; mpv = 0; p1 = '0;
    for (int i = 0; i < 3; i++) begin p5[i] = '0; ps[i] = '0; p8[i] = '0; end
    cyc(1, 1, 0, pk5(1, 2, 3, 4, 5));
    cyc(1, 1, 0, pk5(9, 8, 7, 6, 5));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 40'h0);
      chk("rst_den", den5, 0); chk("rst_val", val5, 0); chk("rst_idx", idx5, 0);
    end
    cyc(0, 1, 0, pk5(11, 22, 33, 44, 55));
    cyc(0, 1, 1, pk5(11, 22, 33, 44, 55));
    cyc(1, 1, 0, pk5(11, 22, 33, 44, 55));
    for (int i = 0; i < 4; i++) begin cyc(0, 0, 0, 40'h0); chk("flush", den5, 0); end
    cyc(0, 1, 0, pk5(10, 200, 30, 40, 50));
    cyc(0, 0, 0, 40'h0);
    cyc(0, 0, 0, 40'h0);
    chk("max_den", den5, 1); chk("max_val", val5, 200); chk("max_idx", idx5, 1);
    cyc(0, 0, 0, 40'h0);
    chk("max_once", den5, 0);
    cyc(0, 1, 0, pk5(7, 7, 7, 7, 7));
    cyc(0, 1, 1, pk5(9, 3, 3, 8, 4));
    cyc(0, 0, 0, 40'h0);
    chk("tie_val", val5, 7); chk("tie_idx", idx5, 0);
    cyc(0, 0, 0, 40'h0);
    chk("min_val", val5, 3); chk("min_idx", idx5, 1);
    cyc(0, 1, 0, pk5(0, 0, 0, 0, 255));
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, i[0], pk5(5, 1, 9, 2, 9));
      if (i == 1) begin chk("odd_val", val5, 255); chk("odd_idx", idx5, 4); end
      if (i >= 2) begin
        chk("alt_den", den5, 1);
        chk("alt_val", val5, i[0] ? 8'd1 : 8'd9);
        chk("alt_idx", idx5, i[0] ? 3'd1 : 3'd2);
      end
    end
    cyc(0, 1, 0, pk5(8'hFF, 8'h01, 8'h80, 8'h00, 8'h7F));
    cyc(0, 1, 1, pk5(8'hFF, 8'h01, 8'h80, 8'h00, 8'h7F));
    cyc(0, 0, 0, 40'h0);
    chk("smax_val", vals, 8'h7F); chk("smax_idx", idxs, 4); chk("umax_val", val5, 8'hFF);
    cyc(0, 0, 0, 40'h0);
    chk("smin_val", vals, 8'h80); chk("smin_idx", idxs, 2);
    cyc(0, 0, 0, 40'h0);
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
    cyc(1, 0, 0, 40'h0);
    cyc(0, 1, 0, pk5(40, 1, 2, 3, 4));
    cyc(0, 1, 0, pk5(5, 90, 6, 7, 8));
    cyc(0, 1, 0, pk5(5, 6, 90, 7, 8));
    cyc(0, 1, 0, pk5(20, 6, 7, 8, 9));
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 40'h0);
    chk("peak_val", pk_val, 90); chk("peak_idx", pk_idx, 1); chk("peak_vld", pk_vld, 1);
    pc = 1;
    cyc(0, 0, 0, 40'h0);
    pc = 0;
    chk("clr_vld", pk_vld, 0); chk("clr_val", pk_val, 0);
    cyc(0, 1, 0, pk5(15, 1, 2, 3, 4));
    cyc(0, 0, 0, 40'h0);
    cyc(0, 0, 0, 40'h0);
    pc = 1;
    cyc(0, 0, 0, 40'h0);
    pc = 0;
    chk("cl_val", pk_val, 15); chk("cl_vld", pk_vld, 1);
`endif
    for (int n = 0; n < 1000; n++) begin
      t = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        for (int e = 0; e < 5; e++) t[e*8+:8] = 8'($urandom_range(0, 3));
`ifdef MAX_MIN_TREE_PEAK_HOLD_EN
      pc = ($urandom_range(0, 15) == 0);
`endif
      cyc($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
